// File: rtl/mc_core_pkg.sv
// Shared encodings for the multicycle core: opcode/funct values, FSM states,
// ALU operations and the NZCV flag bit positions.
package mc_core_pkg;

    localparam logic [1:0] OP_ALU = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_SYS = 2'b11;

    localparam logic [2:0] F_ADD  = 3'b000;
    localparam logic [2:0] F_SUB  = 3'b001;
    localparam logic [2:0] F_AND  = 3'b010;
    localparam logic [2:0] F_ORR  = 3'b011;
    localparam logic [2:0] F_XOR  = 3'b100;
    localparam logic [2:0] F_CMP  = 3'b101;
    localparam logic [2:0] F_LDR  = 3'b000;
    localparam logic [2:0] F_STR  = 3'b001;
    localparam logic [2:0] F_LDI  = 3'b010;
    localparam logic [2:0] F_B    = 3'b000;
    localparam logic [2:0] F_BEQ  = 3'b001;
    localparam logic [2:0] F_BNE  = 3'b010;
    localparam logic [2:0] F_BL   = 3'b011;
    localparam logic [2:0] F_LSL  = 3'b000;
    localparam logic [2:0] F_LSR  = 3'b001;
    localparam logic [2:0] F_ASR  = 3'b010;
    localparam logic [2:0] F_ROR  = 3'b011;
    localparam logic [2:0] F_HALT = 3'b111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR, ALU_XOR,
        ALU_LSL, ALU_LSR, ALU_ASR, ALU_ROR
    } alu_op_e;

    function automatic alu_op_e alu_op_of(input logic [1:0] op, input logic [2:0] funct);
        alu_op_e sel;
        sel = ALU_ADD;
        if (op == OP_SYS) begin
            case (funct)
                F_LSL:   sel = ALU_LSL;
                F_LSR:   sel = ALU_LSR;
                F_ASR:   sel = ALU_ASR;
                F_ROR:   sel = ALU_ROR;
                default: sel = ALU_ADD;
            endcase
        end else begin
            case (funct)
                F_SUB, F_CMP: sel = ALU_SUB;
                F_AND:        sel = ALU_AND;
                F_ORR:        sel = ALU_ORR;
                F_XOR:        sel = ALU_XOR;
                default:      sel = ALU_ADD;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/mc_core_param_alu.sv
// Combinational ALU and single-bit shifter (module mc_alu). Shifts operate on
// operand b; the caller decides whether V is kept for shift instructions.
module mc_alu
    import mc_core_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  alu_op_e           op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] res_o,
    output logic [3:0]        nzcv_o
);
    localparam int M = DATA_W - 1;

    logic [DATA_W:0]   sum_s;
    logic [DATA_W-1:0] res_s;
    logic              c_s;
    logic              v_s;

    // Result, carry and overflow per operation; SUB carry is NOT borrow.
    always_comb begin
        sum_s = '0;
        res_s = '0;
        c_s   = 1'b0;
        v_s   = 1'b0;
        case (op_i)
            ALU_ADD: begin
                sum_s = {1'b0, a_i} + {1'b0, b_i};
                res_s = sum_s[M:0];
                c_s   = sum_s[DATA_W];
                v_s   = (a_i[M] == b_i[M]) && (res_s[M] != a_i[M]);
            end
            ALU_SUB: begin
                sum_s = {1'b0, a_i} + {1'b0, ~b_i} + (DATA_W+1)'(1);
                res_s = sum_s[M:0];
                c_s   = sum_s[DATA_W];
                v_s   = (a_i[M] != b_i[M]) && (res_s[M] != a_i[M]);
            end
            ALU_AND: res_s = a_i & b_i;
            ALU_ORR: res_s = a_i | b_i;
            ALU_XOR: res_s = a_i ^ b_i;
            ALU_LSL: begin
                res_s = {b_i[M-1:0], 1'b0};
                c_s   = b_i[M];
            end
            ALU_LSR: begin
                res_s = {1'b0, b_i[M:1]};
                c_s   = b_i[0];
            end
            ALU_ASR: begin
                res_s = {b_i[M], b_i[M:1]};
                c_s   = b_i[0];
            end
            ALU_ROR: begin
                res_s = {b_i[0], b_i[M:1]};
                c_s   = b_i[0];
            end
            default: res_s = '0;
        endcase
    end

    assign res_o  = res_s;
    assign nzcv_o = {res_s[M], (res_s == '0), c_s, v_s};

endmodule

// File: rtl/mc_core_param.sv
// Parametrised multicycle core: register file, IR, A/B, result register, PC and
// controller FSM. Optional counters cyc_count/inst_count under MC_CORE_PERF_EN.
module mc_core_param
    import mc_core_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int INST_W = 16,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [INST_W-1:0] mem_wdata,
    input  logic [INST_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_dbg
`ifdef MC_CORE_PERF_EN
    ,
    output logic [31:0]       cyc_count,
    output logic [31:0]       inst_count
`endif
);
    localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [RW-1:0] LINK = RW'(NREGS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [3:0]        flags_q, flags_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d, halted_q, halted_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [INST_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [1:0]        op_s;
    logic [2:0]        funct_s;
    logic [RW-1:0]     rd_s, rm_s, rn_s;
    logic [7:0]        imm_s;
    logic              done_s;
    logic              taken_s;
    logic [DATA_W-1:0] alu_res_s;
    logic [3:0]        alu_nzcv_s;

    assign op_s    = ir_q[15:14];
    assign funct_s = ir_q[13:11];
    assign rd_s    = ir_q[8 +: RW];
    assign rm_s    = ir_q[5 +: RW];
    assign rn_s    = ir_q[2 +: RW];
    assign imm_s   = ir_q[7:0];
    assign done_s  = mem_req_q & mem_ready;

    mc_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i   (alu_op_of(op_s, funct_s)),
        .a_i    (a_q),
        .b_i    (b_q),
        .res_o  (alu_res_s),
        .nzcv_o (alu_nzcv_s)
    );

    // Controller next state, datapath updates and next values of the registered memory port.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        flags_d     = flags_q;
        regs_d      = regs_q;
        taken_s     = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (done_s) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                // Sources are latched here, so Rd may safely alias a source.
                a_d     = regs_q[rn_s];
                b_d     = (op_s == OP_MEM) ? regs_q[rd_s] : regs_q[rm_s];
                state_d = S_FETCH;
                case (op_s)
                    OP_ALU: state_d = (funct_s <= F_CMP) ? S_EXEC : S_FETCH;
                    OP_MEM: begin
                        if (funct_s == F_LDR || funct_s == F_STR) begin
                            state_d = S_MEM;
                        end else if (funct_s == F_LDI) begin
                            regs_d[rd_s] = DATA_W'(imm_s);
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                    OP_BR:  state_d = funct_s[2] ? S_FETCH : S_BRANCH;
                    default: begin
                        if (funct_s == F_HALT) begin
                            state_d = S_HALT;
                        end else begin
                            state_d = funct_s[2] ? S_FETCH : S_EXEC;
                        end
                    end
                endcase
            end
            S_EXEC: begin
                res_d   = alu_res_s;
                flags_d = (op_s == OP_SYS) ? {alu_nzcv_s[3:1], flags_q[FLAG_V]} : alu_nzcv_s;
                state_d = S_WB;
            end
            S_MEM: begin
                if (done_s) begin
                    res_d   = mem_we_q ? res_q : mem_rdata[DATA_W-1:0];
                    state_d = mem_we_q ? S_FETCH : S_WB;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB: begin
                if (!(op_s == OP_ALU && funct_s == F_CMP)) begin
                    regs_d[rd_s] = res_q;
                end else begin
                    regs_d[rd_s] = regs_q[rd_s];
                end
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                case (funct_s)
                    F_B:   taken_s = 1'b1;
                    F_BEQ: taken_s = flags_q[FLAG_Z];
                    F_BNE: taken_s = ~flags_q[FLAG_Z];
                    F_BL: begin
                        taken_s      = 1'b1;
                        regs_d[LINK] = DATA_W'(pc_q);
                    end
                    default: taken_s = 1'b0;
                endcase
                pc_d    = taken_s ? ADDR_W'(imm_s) : pc_q;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        mem_req_d   = (state_d == S_FETCH) || (state_d == S_MEM);
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (state_d == S_FETCH) begin
            mem_we_d   = 1'b0;
            mem_addr_d = pc_d;
        end else if (state_d == S_MEM && state_q != S_MEM) begin
            mem_we_d    = (funct_s == F_STR);
            mem_addr_d  = ADDR_W'(regs_q[rn_s]);
            mem_wdata_d = INST_W'(regs_q[rd_s]);
        end else if (state_d != S_MEM) begin
            mem_we_d = 1'b0;
        end else begin
            mem_we_d = mem_we_q;
        end
        halted_d = (state_d == S_HALT);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            flags_q     <= 4'b0000;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            halted_q    <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            halted_q    <= halted_d;
            regs_q      <= regs_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign halted    = halted_q;
    assign pc_dbg    = pc_q;

`ifdef MC_CORE_PERF_EN
    logic [31:0] cyc_q, inst_q;

    // Cycle counter freezes once halted; instruction counter steps per completed fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q  <= 32'd0;
            inst_q <= 32'd0;
        end else begin
            cyc_q  <= halted_q ? cyc_q : cyc_q + 32'd1;
            inst_q <= (state_q == S_FETCH && done_s) ? inst_q + 32'd1 : inst_q;
        end
    end

    assign cyc_count  = cyc_q;
    assign inst_count = inst_q;
`endif

endmodule

// File: tb/tb_mc_core_param.sv
// Directed self-checking bench for mc_core_param with a behavioural unified
// memory whose wait states are set by stall_n.
module tb_mc_core_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ready, halted;
    logic [7:0]  mem_addr, pc_dbg;
    logic [15:0] mem_wdata, mem_rdata;
`ifdef MC_CORE_PERF_EN
    logic [31:0] cyc_count, inst_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int stall_n = 0;
    int wait_cnt = 0;
    int wr_count = 0;
    int we_cyc = 0;
    int we_ok = 0;

    logic        clr = 1'b0;
    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr = 8'h00;
    logic [15:0] ld_data = 16'h0000;
    logic [15:0] mem [256];

    always #5 clk = ~clk;

    mc_core_param dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .halted    (halted),
        .pc_dbg    (pc_dbg)
`ifdef MC_CORE_PERF_EN
        ,
        .cyc_count (cyc_count),
        .inst_count(inst_count)
`endif
    );

    assign mem_rdata = mem[mem_addr];
    assign mem_ready = (wait_cnt >= stall_n);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) wait_cnt <= 0;
        else if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'hF800;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (!rst && mem_req && mem_ready && mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    always @(negedge clk) begin
        if (mem_req && mem_we) begin
            we_cyc <= we_cyc + 1;
            if (mem_addr == 8'h10 && mem_wdata == 16'h00FF) we_ok <= we_ok + 1;
        end
    end

    function automatic logic [15:0] i_alu(input logic [2:0] f, input logic [2:0] rd, input logic [2:0] rn, input logic [2:0] rm);
        return {2'b00, f, rd, rm, rn, 2'b00};
    endfunction
    function automatic logic [15:0] i_ldi(input logic [2:0] rd, input logic [7:0] imm);
        return {2'b01, 3'b010, rd, imm};
    endfunction
    function automatic logic [15:0] i_str(input logic [2:0] rd, input logic [2:0] rn);
        return {2'b01, 3'b001, rd, 3'b000, rn, 2'b00};
    endfunction
    function automatic logic [15:0] i_ldr(input logic [2:0] rd, input logic [2:0] rn);
        return {2'b01, 3'b000, rd, 3'b000, rn, 2'b00};
    endfunction
    function automatic logic [15:0] i_br(input logic [2:0] f, input logic [7:0] tgt);
        return {2'b10, f, 3'b000, tgt};
    endfunction
    function automatic logic [15:0] i_sh(input logic [2:0] f, input logic [2:0] rd, input logic [2:0] rm);
        return {2'b11, f, rd, rm, 3'b000, 2'b00};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        tick(1);
        ld_en   = 1'b0;
    endtask

    task automatic clear_mem();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    // Wait for a fetch request at addr to become visible; timeout is a failed check.
    task automatic wait_fetch(input logic [7:0] addr, output int at);
        bit found;
        found = 1'b0;
        at = 0;
        for (int n = 0; n < 200; n++) begin
            tick(1);
            if (mem_req && !mem_we && mem_addr == addr) begin
                found = 1'b1;
                at = cyc;
                break;
            end
        end
        check_eq($sformatf("fetch_at_%0h", addr), {31'd0, found}, 32'd1);
    endtask

    task automatic wait_halt();
        bit found;
        found = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            tick(1);
            if (halted) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("halt_reached", {31'd0, found}, 32'd1);
    endtask

    int t_a, t_b, t_x, req_seen, wr0, we0, ok0;

    initial begin
        // Program A: arithmetic, flags, loads/stores and branches, zero-wait.
        rst = 1'b1;
        clear_mem();
        load(8'h00, i_ldi(3'd1, 8'h05));
        load(8'h01, i_ldi(3'd2, 8'h03));
        load(8'h02, i_alu(3'b000, 3'd3, 3'd1, 3'd2));
        load(8'h03, i_ldi(3'd4, 8'h40));
        load(8'h04, i_str(3'd3, 3'd4));
        load(8'h05, i_ldi(3'd1, 8'hFF));
        load(8'h06, i_ldi(3'd2, 8'h01));
        load(8'h07, i_alu(3'b000, 3'd3, 3'd1, 3'd2));
        load(8'h08, i_ldi(3'd4, 8'h41));
        load(8'h09, i_str(3'd3, 3'd4));
        load(8'h0A, i_br(3'b001, 8'h0C));
        load(8'h0C, i_alu(3'b001, 3'd5, 3'd2, 3'd1));
        load(8'h0D, i_alu(3'b101, 3'd0, 3'd1, 3'd1));
        load(8'h0E, i_br(3'b010, 8'h30));
        load(8'h0F, i_ldi(3'd6, 8'h80));
        load(8'h10, i_alu(3'b000, 3'd5, 3'd6, 3'd6));
        load(8'h11, i_sh(3'b010, 3'd6, 3'd6));
        load(8'h12, i_ldi(3'd4, 8'h42));
        load(8'h13, i_str(3'd6, 3'd4));
        load(8'h14, i_ldr(3'd7, 3'd4));
        load(8'h15, i_sh(3'b000, 3'd0, 3'd7));
        load(8'h16, i_ldi(3'd4, 8'h43));
        load(8'h17, i_str(3'd0, 3'd4));
        load(8'h18, i_br(3'b011, 8'h30));
        load(8'h30, i_ldi(3'd4, 8'h44));
        load(8'h31, i_str(3'd7, 3'd4));
        load(8'h32, i_alu(3'b100, 3'd2, 3'd1, 3'd6));
        load(8'h33, i_ldi(3'd4, 8'h45));
        load(8'h34, i_str(3'd2, 3'd4));
        load(8'h35, i_br(3'b000, 8'h37));
        check_eq("rst_pc", {24'd0, pc_dbg}, 32'h0);
        check_eq("rst_req", {31'd0, mem_req}, 32'd0);
        check_eq("rst_halted", {31'd0, halted}, 32'd0);
        wr0 = wr_count;
        rst = 1'b0;

        wait_fetch(8'h00, t_a);
        wait_fetch(8'h01, t_b);
        check_eq("lat_ldi", t_b - t_a, 32'd2);
        wait_fetch(8'h02, t_a);
        wait_fetch(8'h03, t_b);
        check_eq("lat_add", t_b - t_a, 32'd4);
        wait_fetch(8'h04, t_a);
        wait_fetch(8'h05, t_b);
        check_eq("lat_str", t_b - t_a, 32'd3);
        wait_fetch(8'h08, t_x);
        check_eq("flags_add_wrap", {28'd0, dut.flags_q}, 32'h6);
        wait_fetch(8'h0A, t_a);
        wait_fetch(8'h0C, t_b);
        check_eq("lat_beq_taken", t_b - t_a, 32'd3);
        wait_fetch(8'h0D, t_x);
        check_eq("flags_sub_borrow", {28'd0, dut.flags_q}, 32'h0);
        wait_fetch(8'h0E, t_x);
        check_eq("flags_cmp_eq", {28'd0, dut.flags_q}, 32'h6);
        wait_fetch(8'h0F, t_x);
        wait_fetch(8'h11, t_x);
        check_eq("flags_add_ovf", {28'd0, dut.flags_q}, 32'h7);
        wait_fetch(8'h12, t_x);
        check_eq("flags_asr", {28'd0, dut.flags_q}, 32'h9);
        wait_fetch(8'h14, t_a);
        wait_fetch(8'h15, t_b);
        check_eq("lat_ldr", t_b - t_a, 32'd4);
        wait_fetch(8'h16, t_x);
        check_eq("flags_lsl", {28'd0, dut.flags_q}, 32'hB);
        wait_fetch(8'h18, t_a);
        wait_fetch(8'h30, t_b);
        check_eq("lat_bl", t_b - t_a, 32'd3);
        wait_fetch(8'h37, t_x);
        tick(1);
        check_eq("halted_in_decode", {31'd0, halted}, 32'd0);
        tick(1);
        check_eq("halted_set", {31'd0, halted}, 32'd1);
        check_eq("halt_pc", {24'd0, pc_dbg}, 32'h38);
        req_seen = 0;
        for (int n = 0; n < 10; n++) begin
            tick(1);
            if (mem_req) req_seen++;
        end
        check_eq("halt_no_req", req_seen, 32'd0);
        check_eq("halt_sticky", {31'd0, halted}, 32'd1);
        check_eq("mem40_add", {16'd0, mem[8'h40]}, 32'h0008);
        check_eq("mem41_wrap", {16'd0, mem[8'h41]}, 32'h0000);
        check_eq("mem42_asr", {16'd0, mem[8'h42]}, 32'h00C0);
        check_eq("mem43_ldr_lsl", {16'd0, mem[8'h43]}, 32'h0080);
        check_eq("mem44_link", {16'd0, mem[8'h44]}, 32'h0019);
        check_eq("mem45_xor", {16'd0, mem[8'h45]}, 32'h003F);
        check_eq("write_count_a", wr_count - wr0, 32'd6);

        // Program B: store held through three wait states.
        rst = 1'b1;
        clear_mem();
        load(8'h00, i_ldi(3'd1, 8'hFF));
        load(8'h01, i_ldi(3'd4, 8'h10));
        load(8'h02, i_str(3'd1, 3'd4));
        stall_n = 3;
        wr0 = wr_count;
        we0 = we_cyc;
        ok0 = we_ok;
        rst = 1'b0;
        wait_halt();
        check_eq("str_we_cycles", we_cyc - we0, 32'd4);
        check_eq("str_stable_cycles", we_ok - ok0, 32'd4);
        check_eq("str_single_write", wr_count - wr0, 32'd1);
        check_eq("str_mem10", {16'd0, mem[8'h10]}, 32'h00FF);

        // Program C: PC wrap at 0xFF, then reset during a stalled fetch.
        rst = 1'b1;
        stall_n = 0;
        clear_mem();
        load(8'h00, i_br(3'b000, 8'hFF));
        load(8'hFF, i_ldi(3'd1, 8'h01));
        rst = 1'b0;
        wait_fetch(8'hFF, t_a);
        tick(1);
        check_eq("pc_wrap", {24'd0, pc_dbg}, 32'h00);
        wait_fetch(8'h00, t_b);
        check_eq("lat_after_wrap", t_b - t_a, 32'd2);
        stall_n = 5;
        wait_fetch(8'hFF, t_a);
        tick(2);
        check_eq("pre_rst_pc", {24'd0, pc_dbg}, 32'hFF);
        check_eq("pre_rst_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        tick(1);
        check_eq("midrst_pc", {24'd0, pc_dbg}, 32'h00);
        check_eq("midrst_req", {31'd0, mem_req}, 32'd0);
        check_eq("midrst_halted", {31'd0, halted}, 32'd0);
        stall_n = 0;

`ifdef MC_CORE_PERF_EN
        // Program D: three instructions plus HALT for the performance counters.
        clear_mem();
        load(8'h00, i_ldi(3'd1, 8'h05));
        load(8'h01, i_ldi(3'd2, 8'h03));
        load(8'h02, i_alu(3'b000, 3'd3, 3'd1, 3'd2));
        check_eq("perf_rst_cyc", cyc_count, 32'd0);
        rst = 1'b0;
        wait_halt();
        check_eq("perf_inst", inst_count, 32'd4);
        check_eq("perf_cyc", cyc_count, 32'd11);
        tick(5);
        check_eq("perf_cyc_frozen", cyc_count, 32'd11);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
